// File: rtl/ale_miner_mc_pkg.sv
// Shared types and helpers for the multi-lane Alephium miner controller.
package ale_miner_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        MINE  = 2'd2,
        FOUND = 2'd3
    } state_e;

    localparam int NONCE_BYTES = 24;

    // Header words that precede the nonce: (length - nonce bytes) / 4.
    function automatic logic [31:0] words_from_len(input logic [31:0] len);
        logic [31:0] body;
        body = len - 32'(NONCE_BYTES);
        return body >> 2;
    endfunction

endpackage

// File: rtl/ale_miner_mc_if.sv
// Bundle of the per-lane signals between the controller and its Miner cores.
interface ale_miner_mc_if #(
    parameter int LANES   = 4,
    parameter int NONCE_W = 192,
    parameter int HASH_W  = 256
);
    // Start/done handshake: CoreStrt_O[i] is a one-cycle start pulse; the core
    // later raises CoreRdy_I[i] as a level, and only its rising edge counts as a
    // completion, with CoreVld_I[i]/CoreHash_I[i] sampled in that same cycle.
    logic [LANES-1:0]         CoreStrt_O;
    logic [LANES*NONCE_W-1:0] CoreNonce_O;
    logic [LANES*32-1:0]      CoreMsg_O;
    logic [LANES-1:0]         CoreNext_I;
    logic [LANES-1:0]         CoreRdy_I;
    logic [LANES-1:0]         CoreVld_I;
    logic [LANES*HASH_W-1:0]  CoreHash_I;

    modport master (
        output CoreStrt_O, CoreNonce_O, CoreMsg_O,
        input  CoreNext_I, CoreRdy_I, CoreVld_I, CoreHash_I
    );

    modport slave (
        input  CoreStrt_O, CoreNonce_O, CoreMsg_O,
        output CoreNext_I, CoreRdy_I, CoreVld_I, CoreHash_I
    );
endinterface

// File: rtl/ale_miner_mc_lane.sv
// One search lane: interleaved nonce, header read pointer and completion edge detect.
module ale_miner_lane #(
    parameter int LANE_IDX   = 0,
    parameter int LANES      = 4,
    parameter int ADDR_WIDTH = 7,
    parameter int NONCE_W    = 192,
    parameter bit CONT       = 1'b0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  init_i,
    input  logic [NONCE_W-1:0]    base_nonce_i,
    input  logic                  start_all_i,
    input  logic                  run_i,
    input  logic                  next_i,
    input  logic                  rdy_i,
    input  logic                  vld_i,
    output logic [ADDR_WIDTH-1:0] rd_addr_o,
    output logic [NONCE_W-1:0]    nonce_o,
    output logic                  strt_o,
    output logic                  done_o,
    output logic                  find_o
);
    logic                  rdy_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
    logic [NONCE_W-1:0]    nonce_q, nonce_d;
    logic                  strt_q, strt_d;
    logic                  restart;

    assign done_o  = rdy_i & ~rdy_q;
    assign find_o  = done_o & vld_i;
    // A find only re-launches the lane when the controller keeps mining.
    assign restart = run_i & done_o & (~vld_i | CONT);

    always_comb begin
        rd_addr_d = rd_addr_q;
        nonce_d   = nonce_q;
        strt_d    = start_all_i | restart;
        if (init_i || start_all_i || restart) begin
            rd_addr_d = '0;
        end else if (run_i && next_i) begin
            rd_addr_d = rd_addr_q + ADDR_WIDTH'(1);
        end
        if (init_i) begin
            nonce_d = base_nonce_i + NONCE_W'(LANE_IDX);
        end else if (restart) begin
            nonce_d = nonce_q + NONCE_W'(LANES);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rdy_q     <= 1'b0;
            rd_addr_q <= '0;
            nonce_q   <= '0;
            strt_q    <= 1'b0;
        end else begin
            rdy_q     <= rdy_i;
            rd_addr_q <= rd_addr_d;
            nonce_q   <= nonce_d;
            strt_q    <= strt_d;
        end
    end

    assign rd_addr_o = rd_addr_q;
    assign nonce_o   = nonce_q;
    assign strt_o    = strt_q;
endmodule

// File: rtl/ale_miner_mc.sv
// Multi-lane miner controller: header RAM, load/mine FSM, find arbiter and hash counter.
module ale_miner_mc
    import ale_miner_pkg::*;
#(
    parameter int LANES        = 4,
    parameter int ADDR_WIDTH   = 7,
    parameter int NONCE_W      = 192,
    parameter int HASH_W       = 256,
    parameter bit STOP_ON_FIND = 1'b1
) (
    input  logic                Clk,
    input  logic                Rst,
    input  logic                UpdateTrigger_I,
    input  logic                Stop_I,
    input  logic [31:0]         ChunkLength_I,
    input  logic [NONCE_W-1:0]  Nonce_I,
    input  logic                Wr_I,
    input  logic [31:0]         Data_I,
    ale_miner_mc_if.master      core_if,
    output logic                VldNonce_O,
    output logic [NONCE_W-1:0]  Nonce_O,
    output logic [HASH_W-1:0]   Hash_O,
    output logic [31:0]         HashCounter_O,
    output logic                Busy_O,
    output logic                Irq_O,
    output state_e              DbgState_O
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] word_num_q, word_num_in, wr_addr_q;
    logic [31:0]           mem [DEPTH];
    logic [31:0]           hash_cnt_q;
    logic [NONCE_W-1:0]    nonce_q;
    logic [HASH_W-1:0]     hash_q;
    logic                  vld_q, irq_q;

    logic                  ctl_abort, load_wr, mine_act, start_all, busy;
    logic                  any_find, halt, run;
    logic [LANES-1:0]      done_w, find_raw, find_w;
    logic [ADDR_WIDTH-1:0] rd_addr [LANES];
    logic [NONCE_W-1:0]    lane_nonce [LANES];
    logic [NONCE_W-1:0]    win_nonce;
    logic [HASH_W-1:0]     win_hash;
    logic [4:0]            pop;
    logic [32:0]           cnt_sum;

    assign word_num_in = ADDR_WIDTH'(words_from_len(ChunkLength_I));
    assign ctl_abort   = UpdateTrigger_I | Stop_I;

    always_ff @(posedge Clk) begin
        if (Rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // A trigger always restarts the load, overriding Stop_I and the current state.
    always_comb begin
        state_d = state_q;
        if (UpdateTrigger_I) begin
            state_d = (word_num_in == '0) ? IDLE : LOAD;
        end else if (Stop_I) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                LOAD:    if (load_wr && wr_addr_q == word_num_q - ADDR_WIDTH'(1)) state_d = MINE;
                MINE:    if (halt) state_d = FOUND;
                default: ;
            endcase
        end
    end

    always_comb begin
        load_wr  = 1'b0;
        mine_act = 1'b0;
        busy     = 1'b0;
        case (state_q)
            LOAD: begin
                busy    = 1'b1;
                load_wr = Wr_I & ~ctl_abort;
            end
            MINE: begin
                busy     = 1'b1;
                mine_act = ~ctl_abort;
            end
            default: ;
        endcase
    end

    assign start_all = (state_q == LOAD) && (state_d == MINE);
    assign find_w    = find_raw & {LANES{mine_act}};
    assign any_find  = |find_w;
    assign halt      = STOP_ON_FIND & any_find;
    assign run       = mine_act & ~halt;

    always_ff @(posedge Clk) begin
        if (load_wr) mem[wr_addr_q] <= Data_I;
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        ale_miner_lane #(
            .LANE_IDX  (g),
            .LANES     (LANES),
            .ADDR_WIDTH(ADDR_WIDTH),
            .NONCE_W   (NONCE_W),
            .CONT      (!STOP_ON_FIND)
        ) u_lane (
            .clk_i       (Clk),
            .rst_i       (Rst),
            .init_i      (UpdateTrigger_I),
            .base_nonce_i(Nonce_I),
            .start_all_i (start_all),
            .run_i       (run),
            .next_i      (core_if.CoreNext_I[g]),
            .rdy_i       (core_if.CoreRdy_I[g]),
            .vld_i       (core_if.CoreVld_I[g]),
            .rd_addr_o   (rd_addr[g]),
            .nonce_o     (lane_nonce[g]),
            .strt_o      (core_if.CoreStrt_O[g]),
            .done_o      (done_w[g]),
            .find_o      (find_raw[g])
        );
        assign core_if.CoreMsg_O[g*32 +: 32]             = mem[rd_addr[g]];
        assign core_if.CoreNonce_O[g*NONCE_W +: NONCE_W] = lane_nonce[g];
    end

    // Scanning downwards leaves the lowest-index finder as the winner.
    always_comb begin
        win_nonce = '0;
        win_hash  = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (find_w[i]) begin
                win_nonce = lane_nonce[i];
                win_hash  = core_if.CoreHash_I[i*HASH_W +: HASH_W];
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < LANES; i++) pop = pop + 5'(done_w[i]);
    end
    assign cnt_sum = {1'b0, hash_cnt_q} + 33'(pop);

    always_ff @(posedge Clk) begin
        if (Rst) begin
            word_num_q <= '0;
            wr_addr_q  <= '0;
            hash_cnt_q <= '0;
            nonce_q    <= '0;
            hash_q     <= '1;
            vld_q      <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            vld_q <= 1'b0;
            if (UpdateTrigger_I) begin
                word_num_q <= word_num_in;
                wr_addr_q  <= '0;
                hash_cnt_q <= '0;
                nonce_q    <= '0;
                hash_q     <= '1;
                irq_q      <= 1'b0;
            end else begin
                if (load_wr) wr_addr_q <= wr_addr_q + ADDR_WIDTH'(1);
                if (state_q == MINE) hash_cnt_q <= cnt_sum[32] ? '1 : cnt_sum[31:0];
                if (any_find) begin
                    vld_q   <= 1'b1;
                    nonce_q <= win_nonce;
                    hash_q  <= win_hash;
                    irq_q   <= 1'b1;
                end
            end
        end
    end

    assign VldNonce_O    = vld_q;
    assign Nonce_O       = nonce_q;
    assign Hash_O        = hash_q;
    assign HashCounter_O = hash_cnt_q;
    assign Busy_O        = busy;
    assign Irq_O         = irq_q;
    assign DbgState_O    = state_q;
endmodule

// File: tb/tb_ale_miner_mc.sv
// Directed bench for ale_miner_mc: a load table plus hand-written mining/abort sequences.
module tb_ale_miner_mc;
    import ale_miner_pkg::*;

    localparam int LANES = 4;
    localparam int AW    = 7;
    localparam int NW    = 192;
    localparam int HW    = 256;

    // ---------------- clock / reset / host signals ----------------
    logic          clk = 1'b0;
    logic          rst, trig, stop, wr;
    logic [31:0]   len, data;
    logic [NW-1:0] nonce_in;

    always #5 clk = ~clk;

    ale_miner_mc_if #(.LANES(LANES), .NONCE_W(NW), .HASH_W(HW)) core_if ();
    ale_miner_mc_if #(.LANES(LANES), .NONCE_W(NW), .HASH_W(HW)) c_if ();

    logic          vld_nonce, busy, irq;
    logic [NW-1:0] nonce_o;
    logic [HW-1:0] hash_o;
    logic [31:0]   cnt_o;
    state_e        st;

    logic          c_vld, c_busy, c_irq;
    logic [NW-1:0] c_nonce;
    logic [HW-1:0] c_hash;
    logic [31:0]   c_cnt;
    state_e        c_st;

    ale_miner_mc #(.LANES(LANES), .ADDR_WIDTH(AW), .NONCE_W(NW), .HASH_W(HW), .STOP_ON_FIND(1'b1)) dut (
        .Clk(clk), .Rst(rst), .UpdateTrigger_I(trig), .Stop_I(stop), .ChunkLength_I(len),
        .Nonce_I(nonce_in), .Wr_I(wr), .Data_I(data), .core_if(core_if),
        .VldNonce_O(vld_nonce), .Nonce_O(nonce_o), .Hash_O(hash_o), .HashCounter_O(cnt_o),
        .Busy_O(busy), .Irq_O(irq), .DbgState_O(st)
    );

    ale_miner_mc #(.LANES(LANES), .ADDR_WIDTH(AW), .NONCE_W(NW), .HASH_W(HW), .STOP_ON_FIND(1'b0)) dut_c (
        .Clk(clk), .Rst(rst), .UpdateTrigger_I(trig), .Stop_I(stop), .ChunkLength_I(len),
        .Nonce_I(nonce_in), .Wr_I(wr), .Data_I(data), .core_if(c_if),
        .VldNonce_O(c_vld), .Nonce_O(c_nonce), .Hash_O(c_hash), .HashCounter_O(c_cnt),
        .Busy_O(c_busy), .Irq_O(c_irq), .DbgState_O(c_st)
    );

    // ---------------- scoreboard ----------------
    int            checks = 0;
    int            errors = 0;
    logic [NW-1:0] exp_q[$];
    logic [NW-1:0] exp_w;

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Every winning-nonce pulse of the stop-on-find DUT must match a queued expectation.
    always @(negedge clk) begin
        if (!rst && vld_nonce) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL vld_nonce_unexpected: got pulse with nonce %0h, expected none", nonce_o);
            end else begin
                exp_w = exp_q.pop_front();
                if (nonce_o !== exp_w) begin
                    errors++;
                    $display("FAIL vld_nonce_value: got %0h expected %0h", nonce_o, exp_w);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] l, input logic [NW-1:0] b, input int nwr, input logic [31:0] d0);
        len      = l;
        nonce_in = b;
        trig     = 1'b1;
        tick();
        trig = 1'b0;
        for (int j = 0; j < nwr; j++) begin
            wr   = 1'b1;
            data = d0 + 32'(j);
            tick();
        end
        wr = 1'b0;
        #1;
    endtask

    function automatic logic [NW-1:0] lane_n(input int i);
        return core_if.CoreNonce_O[i*NW +: NW];
    endfunction

    function automatic logic [31:0] lane_msg(input int i);
        return core_if.CoreMsg_O[i*32 +: 32];
    endfunction

    function automatic logic [HW-1:0] lane_hash(input int i);
        logic [31:0] w;
        w = 32'hC0DE_0000 | 32'(i);
        return {8{w}};
    endfunction

    typedef struct {
        logic [31:0]   len;
        logic [NW-1:0] base;
        int            nwr;
        logic [31:0]   d0;
        state_e        st;
        logic [NW-1:0] n0;
        logic [NW-1:0] n3;
    } load_vec_t;

    load_vec_t lv[4];

    initial begin
        lv[0] = '{32'd24, 192'd5,                   0, 32'h0,   IDLE, 192'd5,                   192'd8};
        lv[1] = '{32'd36, {NW{1'b1}} - NW'(1),      3, 32'h100, MINE, {NW{1'b1}} - NW'(1),      192'd1};
        lv[2] = '{32'd28, 192'd7,                   1, 32'h200, MINE, 192'd7,                   192'd10};
        lv[3] = '{32'd32, 192'd100,                 2, 32'hA,   MINE, 192'd100,                 192'd103};

        rst = 1'b1; trig = 1'b0; stop = 1'b0; wr = 1'b0;
        len = '0; data = '0; nonce_in = '0;
        core_if.CoreNext_I = '0; core_if.CoreRdy_I = '0; core_if.CoreVld_I = '0;
        c_if.CoreNext_I = '0; c_if.CoreRdy_I = '0; c_if.CoreVld_I = '0;
        for (int i = 0; i < LANES; i++) begin
            core_if.CoreHash_I[i*HW +: HW] = lane_hash(i);
            c_if.CoreHash_I[i*HW +: HW]    = lane_hash(i);
        end
        tick();
        tick();

        check("rst_state", 256'(st), 256'(IDLE));
        check("rst_busy", 256'(busy), 256'd0);
        check("rst_irq", 256'(irq), 256'd0);
        check("rst_vld", 256'(vld_nonce), 256'd0);
        check("rst_nonce", 256'(nonce_o), 256'd0);
        check("rst_hash", hash_o, {256{1'b1}});
        check("rst_cnt", 256'(cnt_o), 256'd0);
        check("rst_strt", 256'(core_if.CoreStrt_O), 256'd0);
        check("rst_lane_nonce", 256'(core_if.CoreNonce_O), 256'd0);
        rst = 1'b0;
        tick();

        // ---- table: load header, enter MINE (or not), check lane setup ----
        for (int k = 0; k < 4; k++) begin
            load(lv[k].len, lv[k].base, lv[k].nwr, lv[k].d0);
            check("tbl_state", 256'(st), 256'(lv[k].st));
            check("tbl_busy", 256'(busy), 256'(lv[k].st == MINE));
            if (lv[k].st == MINE) begin
                check("tbl_strt_all", 256'(core_if.CoreStrt_O), 256'(4'b1111));
                check("tbl_lane0_nonce", 256'(lane_n(0)), 256'(lv[k].n0));
                check("tbl_lane3_nonce", 256'(lane_n(3)), 256'(lv[k].n3));
                check("tbl_msg0", 256'(lane_msg(0)), 256'(lv[k].d0));
                check("tbl_msg3", 256'(lane_msg(3)), 256'(lv[k].d0));
                check("tbl_cnt", 256'(cnt_o), 256'd0);
                check("tbl_hash", hash_o, {256{1'b1}});
            end else begin
                check("tbl_strt_none", 256'(core_if.CoreStrt_O), 256'd0);
            end
        end

        // ---- nonce interleave and read advance (table left us in first MINE cycle) ----
        check("ld_n1", 256'(lane_n(1)), 256'd101);
        check("ld_n2", 256'(lane_n(2)), 256'd102);
        core_if.CoreNext_I = 4'b0001;
        tick();
        core_if.CoreNext_I = '0;
        #1;
        check("strt_one_cycle", 256'(core_if.CoreStrt_O), 256'd0);
        check("msg0_after_next", 256'(lane_msg(0)), 256'hB);
        check("msg1_no_next", 256'(lane_msg(1)), 256'hA);

        // ---- invalid completion on lane 2 ----
        core_if.CoreRdy_I = 4'b0100;
        tick();
        check("inv_strt2", 256'(core_if.CoreStrt_O), 256'(4'b0100));
        check("inv_nonce2", 256'(lane_n(2)), 256'd106);
        check("inv_cnt", 256'(cnt_o), 256'd1);
        check("inv_msg2_rewound", 256'(lane_msg(2)), 256'hA);
        core_if.CoreRdy_I = '0;
        tick();
        check("inv_strt_clear", 256'(core_if.CoreStrt_O), 256'd0);

        // ---- simultaneous finds on lanes 1 and 3 ----
        exp_q.push_back(192'd101);
        core_if.CoreRdy_I = 4'b1010;
        core_if.CoreVld_I = 4'b1010;
        tick();
        check("find_vld", 256'(vld_nonce), 256'd1);
        check("find_nonce", 256'(nonce_o), 256'd101);
        check("find_hash", hash_o, lane_hash(1));
        check("find_irq", 256'(irq), 256'd1);
        check("find_state", 256'(st), 256'(FOUND));
        check("find_cnt", 256'(cnt_o), 256'd3);
        check("find_no_strt", 256'(core_if.CoreStrt_O), 256'd0);
        core_if.CoreRdy_I = '0;
        core_if.CoreVld_I = '0;
        tick();
        check("find_vld_single", 256'(vld_nonce), 256'd0);
        check("found_busy", 256'(busy), 256'd0);

        core_if.CoreRdy_I = 4'b0001;
        core_if.CoreVld_I = 4'b0001;
        tick();
        check("found_ignore_state", 256'(st), 256'(FOUND));
        check("found_ignore_cnt", 256'(cnt_o), 256'd3);
        check("found_ignore_nonce", 256'(nonce_o), 256'd101);
        check("found_ignore_strt", 256'(core_if.CoreStrt_O), 256'd0);
        core_if.CoreRdy_I = '0;
        core_if.CoreVld_I = '0;
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("found_stop_state", 256'(st), 256'(IDLE));
        check("found_stop_irq", 256'(irq), 256'd1);
        check("found_stop_nonce", 256'(nonce_o), 256'd101);

        // ---- Stop_I mid-MINE, later completions ignored ----
        load(32'd32, 192'd200, 2, 32'h20);
        check("stop_ld_irq", 256'(irq), 256'd0);
        check("stop_ld_hash", hash_o, {256{1'b1}});
        core_if.CoreRdy_I = 4'b0001;
        tick();
        core_if.CoreRdy_I = '0;
        check("stop_pre_cnt", 256'(cnt_o), 256'd1);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_state", 256'(st), 256'(IDLE));
        check("stop_busy", 256'(busy), 256'd0);
        check("stop_cnt_kept", 256'(cnt_o), 256'd1);
        core_if.CoreRdy_I = 4'b0010;
        core_if.CoreVld_I = 4'b0010;
        tick();
        check("stop_late_vld", 256'(vld_nonce), 256'd0);
        check("stop_late_irq", 256'(irq), 256'd0);
        check("stop_late_cnt", 256'(cnt_o), 256'd1);
        check("stop_late_strt", 256'(core_if.CoreStrt_O), 256'd0);
        core_if.CoreRdy_I = '0;
        core_if.CoreVld_I = '0;
        tick();

        // ---- UpdateTrigger_I together with Stop_I ----
        load(32'd32, 192'd300, 2, 32'h30);
        core_if.CoreRdy_I = 4'b0001;
        tick();
        core_if.CoreRdy_I = '0;
        check("ts_pre_cnt", 256'(cnt_o), 256'd1);
        trig = 1'b1;
        stop = 1'b1;
        tick();
        trig = 1'b0;
        stop = 1'b0;
        check("ts_state", 256'(st), 256'(LOAD));
        check("ts_cnt", 256'(cnt_o), 256'd0);
        check("ts_busy", 256'(busy), 256'd1);
        for (int j = 0; j < 2; j++) begin
            wr   = 1'b1;
            data = 32'h40 + 32'(j);
            tick();
        end
        wr = 1'b0;
        #1;
        check("ts_mine", 256'(st), 256'(MINE));
        check("ts_strt", 256'(core_if.CoreStrt_O), 256'(4'b1111));

        // ---- counter saturation with four simultaneous completions ----
        force dut.hash_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.hash_cnt_q;
        core_if.CoreRdy_I = 4'b1111;
        tick();
        check("sat_cnt", 256'(cnt_o), 256'hFFFF_FFFF);
        check("sat_strt", 256'(core_if.CoreStrt_O), 256'(4'b1111));
        core_if.CoreRdy_I = '0;
        tick();
        core_if.CoreRdy_I = 4'b0011;
        tick();
        core_if.CoreRdy_I = '0;
        check("sat_hold", 256'(cnt_o), 256'hFFFF_FFFF);

        // ---- continue mode: lane 0 finds and keeps mining ----
        load(32'd32, 192'd100, 2, 32'hA);
        c_if.CoreRdy_I = 4'b0001;
        c_if.CoreVld_I = 4'b0001;
        tick();
        check("cont_vld", 256'(c_vld), 256'd1);
        check("cont_nonce", 256'(c_nonce), 256'd100);
        check("cont_hash", c_hash, lane_hash(0));
        check("cont_lane0", 256'(c_if.CoreNonce_O[0 +: NW]), 256'd104);
        check("cont_strt", 256'(c_if.CoreStrt_O), 256'(4'b0001));
        check("cont_state", 256'(c_st), 256'(MINE));
        check("cont_busy", 256'(c_busy), 256'd1);
        check("cont_irq", 256'(c_irq), 256'd1);
        check("cont_cnt", 256'(c_cnt), 256'd1);
        c_if.CoreRdy_I = '0;
        c_if.CoreVld_I = '0;
        tick();
        check("cont_vld_clear", 256'(c_vld), 256'd0);

        // ---- reset mid-operation ----
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_state", 256'(st), 256'(IDLE));
        check("mrst_hash", hash_o, {256{1'b1}});
        check("mrst_lane_nonce", 256'(core_if.CoreNonce_O), 256'd0);
        check("mrst_busy", 256'(c_busy), 256'd0);

        check("sb_queue_empty", 256'(exp_q.size()), 256'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
